// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector for slow SDIO control inputs.
// Each channel is synchronised, glitch-filtered, edge-qualified and flagged.
module edge_detector_bank #(
   parameter int   WIDTH       = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_LEN  = 3,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   sig,
   input  logic [2*WIDTH-1:0] mode,
   input  logic [WIDTH-1:0]   clr,
   output logic [WIDTH-1:0]   level,
   output logic [WIDTH-1:0]   pulse,
   output logic [WIDTH-1:0]   flag,
   output logic               irq
);

   localparam int          CW    = $clog2(FILTER_LEN + 1);
   localparam logic [CW:0] LIMIT = (CW+1)'(FILTER_LEN);

   logic r_irq;

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_ch
         logic [SYNC_STAGES-1:0] r_sync;
         logic [CW-1:0]          r_cnt;
         logic                   r_level;
         logic                   r_pulse;
         logic                   r_flag;
         logic                   w_s;
         logic                   w_diff;
         logic                   w_fire;
         logic                   w_qual;

         assign w_s    = r_sync[SYNC_STAGES-1];
         assign w_diff = (w_s != r_level);
         assign w_fire = w_diff &&
                         (({1'b0, r_cnt} + (CW+1)'(1)) == LIMIT);

         // The new level is ~r_level: mode bit 0 qualifies rises, bit 1 falls
         assign w_qual = w_fire &&
                         (r_level ? mode[2*g+1] : mode[2*g]);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_sync  <= {SYNC_STAGES{RESET_LEVEL}};
               r_cnt   <= '0;
               r_level <= RESET_LEVEL;
               r_pulse <= 1'b0;
               r_flag  <= 1'b0;
            end else begin
               r_sync  <= (r_sync << 1) | SYNC_STAGES'(sig[g]);
               r_pulse <= w_qual;
               r_flag  <= w_qual | (r_flag & ~clr[g]);
               if (w_fire) begin
                  r_level <= w_s;
                  r_cnt   <= '0;
               end else if (w_diff) begin
                  r_cnt   <= r_cnt + CW'(1);
               end else begin
                  r_cnt   <= '0;
               end
            end
         end

         assign level[g] = r_level;
         assign pulse[g] = r_pulse;
         assign flag[g]  = r_flag;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |flag;
      end
   end

   assign irq = r_irq;

endmodule
